// File: rtl/grid_input_feeder_if.sv
// rtl/grid_input_feeder_if.sv - grid west-input handshake (packet / empty / read-enable)
//
// Purpose: bundles the grid's input-buffer handshake so the feeder and the
// grid (or a bench standing in for it) connect through one port.
//   packet_in           : head packet, driven by the feeder
//   input_buffer_empty  : no releasable packet, driven by the feeder
//   ren_to_input_buffer : pop strobe, driven by the grid
// Modports: master = feeder side, slave = grid side.

interface grid_input_feeder_if #(
    parameter int PACKET_WIDTH = 30
) ();
    logic [PACKET_WIDTH-1:0] packet_in;
    logic                    input_buffer_empty;
    logic                    ren_to_input_buffer;

    modport master (
        output packet_in,
        output input_buffer_empty,
        input  ren_to_input_buffer
    );

    modport slave (
        input  packet_in,
        input  input_buffer_empty,
        output ren_to_input_buffer
    );
endinterface

// File: rtl/grid_input_feeder.sv
// rtl/grid_input_feeder.sv - tick-gated show-ahead packet FIFO feeding the grid west input
//
// Purpose: stores pre-routed spike packets tagged with a frame tick stamp and
// presents the head packet to the grid once the grid tick count has reached
// its stamp. Release is strictly in order.
// Build option: define GRID_FEEDER_TICK_GATE_EN to build stamp storage and the
// tick gate; without it the block is a plain show-ahead FIFO and
// tick_i / frame_start_i / wr_stamp_i are ignored.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   tick_i            : one-cycle grid tick pulse, advances the tick counter
//   frame_start_i     : clears the tick counter (wins over tick_i)
//   wr_en_i           : host write strobe
//   wr_packet_i       : packet to enqueue
//   wr_stamp_i        : tick at which the packet becomes releasable
//   full_o, count_o   : occupancy status
//   overflow_error_o  : sticky, write while full
//   underflow_error_o : sticky, read while nothing releasable
//   grid              : grid handshake (packet_in / input_buffer_empty / ren)

module grid_input_feeder #(
    parameter int PACKET_WIDTH = 30,
    parameter int DEPTH        = 16,
    parameter int STAMP_WIDTH  = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      tick_i,
    input  logic                      frame_start_i,
    input  logic                      wr_en_i,
    input  logic [PACKET_WIDTH-1:0]   wr_packet_i,
    input  logic [STAMP_WIDTH-1:0]    wr_stamp_i,
    output logic                      full_o,
    output logic [$clog2(DEPTH):0]    count_o,
    output logic                      overflow_error_o,
    output logic                      underflow_error_o,
    grid_input_feeder_if.master       grid
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [PACKET_WIDTH-1:0] pkt_mem [DEPTH];

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;

    logic full_w;
    logic empty_w;
    logic head_blocked;
    logic do_wr;
    logic do_rd;

`ifdef GRID_FEEDER_TICK_GATE_EN
    logic [STAMP_WIDTH-1:0] stamp_mem [DEPTH];
    logic [STAMP_WIDTH-1:0] cur_tick_q, cur_tick_d;

    // Late packets (stamp below the current tick) release immediately.
    assign head_blocked = stamp_mem[rptr_q] > cur_tick_q;

    always_comb begin
        cur_tick_d = cur_tick_q;
        if (frame_start_i) begin
            cur_tick_d = '0;
        end else if (tick_i && (cur_tick_q != {STAMP_WIDTH{1'b1}})) begin
            cur_tick_d = cur_tick_q + STAMP_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_tick_q <= '0;
        end else begin
            cur_tick_q <= cur_tick_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            stamp_mem[wptr_q] <= wr_stamp_i;
        end
    end
`else
    logic unused_gate_inputs;
    assign unused_gate_inputs = ^{tick_i, frame_start_i, wr_stamp_i};
    assign head_blocked       = 1'b0;
`endif

    // Status comes from registered state only; the strobes never reach outputs.
    assign full_w  = (count_q == CW'(DEPTH));
    assign empty_w = (count_q == '0) || head_blocked;

    // full_w is the pre-pop state, so a write alongside a pop while full is dropped.
    assign do_wr = wr_en_i && !full_w;
    assign do_rd = grid.ren_to_input_buffer && !empty_w;

    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q  | (wr_en_i && full_w);
        underflow_d = underflow_q | (grid.ren_to_input_buffer && empty_w);

        if (do_wr) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (do_rd) begin
            rptr_d = rptr_q + AW'(1);
        end

        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Packet storage is not reset; reset only discards it through the pointers.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            pkt_mem[wptr_q] <= wr_packet_i;
        end
    end

    assign full_o                  = full_w;
    assign count_o                 = count_q;
    assign overflow_error_o        = overflow_q;
    assign underflow_error_o       = underflow_q;
    assign grid.input_buffer_empty = empty_w;
    assign grid.packet_in          = (count_q == '0) ? '0 : pkt_mem[rptr_q];

endmodule

// File: doc/grid_input_feeder.md
# grid_input_feeder

Tick-gated input packet source for the west input port of the RANC network grid (`packet_in` / `input_buffer_empty` / `ren_to_input_buffer`). A host or testbench loader writes pre-routed 30-bit spike packets, each tagged with a frame tick stamp. The block stores them in a show-ahead FIFO and presents the head packet to the grid only once the grid tick count has reached that stamp. It is the writer/transmitter end of the grid's empty/read-enable input handshake.

## Interface
Parameters:
- `PACKET_WIDTH`, 30: packet width. Field layout is dx[29:21], dy[20:12], axon[11:4], tick[3:0].
- `DEPTH`, 16: FIFO entries. Must be a power of two, ≥2.
- `STAMP_WIDTH`, 8: width of the frame tick stamp and of the internal tick counter.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `tick` in 1: one-cycle grid tick pulse. Same signal that drives the cores.
- `frame_start` in 1: clears the tick counter at the start of a new frame.
- `wr_en` in 1: host write strobe.
- `wr_packet` in PACKET_WIDTH: packet to enqueue.
- `wr_stamp` in STAMP_WIDTH: tick at which the packet becomes releasable.
- `full` out 1: FIFO holds DEPTH entries.
- `count` out $clog2(DEPTH)+1: current occupancy.
- `input_buffer_empty` out 1: no releasable packet; drives the grid's empty input.
- `packet_in` out PACKET_WIDTH: head packet; drives the grid's packet input.
- `ren_to_input_buffer` in 1: grid read enable (pop).
- `overflow_error` out 1: sticky; set by a write while full.
- `underflow_error` out 1: sticky; set by a read while `input_buffer_empty`.

## Operation
- Storage:
  - Circular buffer of {stamp, packet} with read and write pointers of $clog2(DEPTH) bits, wrapping modulo DEPTH.
  - `count` is tracked separately.
- Write:
  - `wr_en && !full` stores the entry at wptr and increments wptr and count.
  - `wr_en && full` drops the packet and sets `overflow_error`.
  - `full` is evaluated on the pre-pop state: a write in the same cycle as a pop while full is still dropped.
- Tick counter `cur_tick`:
  - `tick` increments it, saturating at 2^STAMP_WIDTH−1 (no wrap).
  - `frame_start` loads 0.
  - `frame_start` and `tick` in the same cycle: `frame_start` wins, so the result is 0.
- Release:
  - `input_buffer_empty = (count==0) || (head_stamp > cur_tick)`, unsigned compare.
  - Late packets (stamp < cur_tick) are released immediately.
  - Release is strictly in order: a blocked head blocks all later entries.
- `packet_in`:
  - Equals the head packet whenever count>0, regardless of gating.
  - Equals 0 when count==0.
- Read:
  - `ren_to_input_buffer && !input_buffer_empty` advances rptr and decrements count.
  - `ren_to_input_buffer && input_buffer_empty` is ignored and sets `underflow_error`.
- Simultaneous read and write (not full): count is unchanged and both pointers advance.
- Sticky errors clear only on `reset`.
- Reset:
  - Pointers, count and `cur_tick` are cleared.
  - Outputs: `input_buffer_empty`=1, `packet_in`=0, `full`=0, `count`=0, both errors 0.
  - Reset mid-frame discards all stored packets.
  - Memory contents are not cleared.

## Timing
- A write at cycle t is visible at t+1: count, `full`, `packet_in`, and `input_buffer_empty` if the entry is releasable.
- A `tick` at cycle t updates `cur_tick` at t+1. Gating is re-evaluated combinationally from registers, so a newly releasable head asserts `input_buffer_empty`=0 at t+1.
- A pop at t presents the next head on `packet_in` at t+1.
- Back-to-back `ren` every cycle is supported, giving a throughput of 1 packet/cycle.
- `input_buffer_empty`, `packet_in` and `full` are combinational from registered state only. There is no path from `ren_to_input_buffer` or `wr_en` to any output.

## Configuration
- `GRID_FEEDER_TICK_GATE_EN`:
  - Defined: stamp storage and gating are as described above.
  - Undefined: `wr_stamp`, `tick` and `frame_start` are ignored, no stamp storage is built, and `input_buffer_empty = (count==0)`, giving a plain show-ahead FIFO.
  - All ports exist in both builds.

## Test plan
- Reset then idle: `input_buffer_empty`=1, `packet_in`=0, `count`=0, both errors 0.
- Gating:
  - Write packet 0x0200_0015 with stamp 2 while cur_tick=0: `count`=1, `packet_in`=0x0200_0015, `input_buffer_empty` stays 1.
  - After two `tick` pulses, `input_buffer_empty`=0 one cycle after the second tick.
  - `ren` pops the packet and `input_buffer_empty` returns to 1.
- Ordering:
  - Write stamps 3,1,1.
  - After one tick, empty stays 1 because the head is blocked.
  - After the third tick, all three pop on consecutive `ren` cycles in write order.
- Capacity:
  - Fill 16 entries with stamp 0: `full`=1, `count`=16.
  - A 17th write is dropped and `overflow_error`=1; a write together with a pop while full is also dropped.
  - Pointers wrap correctly after 20 further write/pop pairs.
- Errors and frame reset:
  - `ren` while empty leaves `count` unchanged and sets `underflow_error`=1.
  - `frame_start` together with `tick` at cur_tick=5 gives cur_tick=0.
  - 300 ticks saturate `cur_tick` at 255.
- Build without `GRID_FEEDER_TICK_GATE_EN`: a write with stamp 200 is releasable the next cycle with no ticks applied.
